iram_bitrmw_ctrl: RTL and testbench

Parametrised, fully synchronous successor to the 8051 internal data memory.
- Holds three regions:
  - lower RAM, 00h-7Fh;
  - SFR space, direct 80h-FFh;
  - optional upper RAM, indirect 80h-FFh.
- Serves byte and bit accesses through a valid/ready request port.
- Bit writes are a two-cycle read-modify-write.
- A post-reset init sweep clears all storage.

---
 rtl/iram_bitrmw_ctrl_if.sv | 32 +++
 rtl/iram_bitrmw_ctrl.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_iram_bitrmw_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/iram_bitrmw_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : iram_bitrmw_ctrl_if
// Brief    : Request/response bus of the 8051-style internal data memory.
// Revision : 1.0 - initial release
// ============================================================================
interface iram_bitrmw_ctrl_if;
    logic       req;
    logic       ready;
    logic       we;
    logic       is_bit;
    logic       indirect;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       wbit;
    logic       rvalid;
    logic [7:0] rdata;
    logic       rbit;
    logic       err;
    logic       init_done;

    modport master (
        output req, we, is_bit, indirect, addr, wdata, wbit,
        input  ready, rvalid, rdata, rbit, err, init_done
    );

    modport slave (
        input  req, we, is_bit, indirect, addr, wdata, wbit,
        output ready, rvalid, rdata, rbit, err, init_done
    );
endinterface
`default_nettype wire

// File: rtl/iram_bitrmw_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : iram_bitrmw_ctrl
// Brief    : 8051 internal data memory (lower RAM, SFR, optional upper RAM)
//            with byte/bit access, two-cycle bit RMW and post-reset clear.
//            Optional per-byte even parity: define IRAM_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module iram_bitrmw_ctrl #(
    parameter int         LOW_DEPTH  = 128,
    parameter int         UPPER_EN   = 1,
    parameter logic [7:0] FILL_VALUE = 8'h00,
    parameter logic [7:0] SFR_FILL   = 8'h00
) (
    input  wire               clock,
    input  wire               reset,
    iram_bitrmw_ctrl_if.slave bus
);

`ifdef IRAM_PARITY_EN
    localparam int c_W = 9;
`else
    localparam int c_W = 8;
`endif

    localparam logic [1:0] c_ST_INIT = 2'd0;
    localparam logic [1:0] c_ST_IDLE = 2'd1;
    localparam logic [1:0] c_ST_RMW  = 2'd2;

    localparam logic [1:0] c_RG_LOW  = 2'd0;
    localparam logic [1:0] c_RG_SFR  = 2'd1;
    localparam logic [1:0] c_RG_UP   = 2'd2;

    function automatic logic [c_W-1:0] f_enc(input logic [7:0] b);
`ifdef IRAM_PARITY_EN
        f_enc = {^b, b};
`else
        f_enc = b;
`endif
    endfunction

    logic [1:0]     r_state;
    logic [1:0]     w_state_nx;
    logic [6:0]     r_cnt;
    logic           w_accept;

    logic [1:0]     w_region;
    logic [6:0]     w_idx;
    logic [2:0]     w_bsel;
    logic           w_illegal;

    logic [c_W-1:0] r_lower [LOW_DEPTH];
    logic [c_W-1:0] r_sfr   [128];
    logic [c_W-1:0] w_lo_rd;
    logic [c_W-1:0] w_sfr_rd;
    logic [c_W-1:0] w_up_rd;
    logic [c_W-1:0] w_rd_word;
    logic [7:0]     w_rd_byte;
    logic           w_rd_bad;

    logic [1:0]     r_rmw_region;
    logic [6:0]     r_rmw_idx;
    logic [2:0]     r_rmw_bsel;
    logic           r_rmw_wbit;
    logic [7:0]     r_rmw_byte;
`ifdef IRAM_PARITY_EN
    logic           r_rmw_bad;
`endif
    logic [7:0]     w_merged;
    logic           w_rmw_abort;

    logic           w_lo_we;
    logic           w_sfr_we;
    logic           w_up_we;
    logic [6:0]     w_wr_idx;
    logic [c_W-1:0] w_wd;
    logic [c_W-1:0] w_sfr_wd;

    logic           r_rvalid;
    logic [7:0]     r_rdata;
    logic           r_rbit;
    logic           r_err;

    assign w_accept      = (r_state == c_ST_IDLE) && bus.req;
    assign bus.ready     = (r_state == c_ST_IDLE);
    assign bus.init_done = (r_state != c_ST_INIT);
    assign bus.rvalid    = r_rvalid;
    assign bus.rdata     = r_rdata;
    assign bus.rbit      = r_rbit;
    assign bus.err       = r_err;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_INIT;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            c_ST_INIT: if (r_cnt == 7'd127) w_state_nx = c_ST_IDLE;
            c_ST_IDLE: if (w_accept && bus.we && bus.is_bit) w_state_nx = c_ST_RMW;
            c_ST_RMW:  w_state_nx = c_ST_IDLE;
            default:   w_state_nx = c_ST_INIT;
        endcase
    end

    // ------------------------------------------------------------------
    // Address decode: bit addresses 00h-7Fh live in bytes 20h-2Fh,
    // 80h-FFh in the bit-addressable SFRs (addresses ending in 0h/8h).
    // ------------------------------------------------------------------
    always_comb begin
        w_region  = c_RG_LOW;
        w_idx     = bus.addr[6:0];
        w_bsel    = bus.addr[2:0];
        w_illegal = 1'b0;
        if (bus.is_bit) begin
            if (!bus.addr[7]) begin
                w_region = c_RG_LOW;
                w_idx    = {3'b010, bus.addr[6:3]};
            end else begin
                w_region = c_RG_SFR;
                w_idx    = {bus.addr[6:3], 3'b000};
            end
        end else if (bus.addr[7]) begin
            if (!bus.indirect) begin
                w_region = c_RG_SFR;
            end else begin
                w_region  = c_RG_UP;
                w_illegal = (UPPER_EN == 0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_lo_we) r_lower[w_wr_idx] <= w_wd;
    end

    always_ff @(posedge clock) begin
        if (w_sfr_we) r_sfr[w_wr_idx] <= w_sfr_wd;
    end

    generate
        if (UPPER_EN != 0) begin : g_upper
            logic [c_W-1:0] r_upper [128];
            always_ff @(posedge clock) begin
                if (w_up_we) r_upper[w_wr_idx] <= w_wd;
            end
            assign w_up_rd = r_upper[w_idx];
        end else begin : g_no_upper
            logic w_unused_up;
            assign w_unused_up = w_up_we;
            assign w_up_rd     = '0;
        end
    endgenerate

    assign w_lo_rd  = r_lower[w_idx];
    assign w_sfr_rd = r_sfr[w_idx];

    always_comb begin
        w_rd_word = w_lo_rd;
        case (w_region)
            c_RG_SFR: w_rd_word = w_sfr_rd;
            c_RG_UP:  w_rd_word = w_up_rd;
            default:  w_rd_word = w_lo_rd;
        endcase
    end

    assign w_rd_byte = w_rd_word[7:0];
`ifdef IRAM_PARITY_EN
    assign w_rd_bad    = ^w_rd_word;
    assign w_rmw_abort = (r_state == c_ST_RMW) && r_rmw_bad;
`else
    assign w_rd_bad    = 1'b0;
    assign w_rmw_abort = 1'b0;
`endif

    always_comb begin
        w_merged             = r_rmw_byte;
        w_merged[r_rmw_bsel] = r_rmw_wbit;
    end

    // ------------------------------------------------------------------
    // Single shared write port per array: sweep, byte write or RMW.
    // ------------------------------------------------------------------
    always_comb begin
        w_lo_we  = 1'b0;
        w_sfr_we = 1'b0;
        w_up_we  = 1'b0;
        w_wr_idx = r_cnt;
        w_wd     = f_enc(FILL_VALUE);
        w_sfr_wd = f_enc(SFR_FILL);
        case (r_state)
            c_ST_INIT: begin
                w_lo_we  = 1'b1;
                w_sfr_we = 1'b1;
                w_up_we  = (UPPER_EN != 0);
            end
            c_ST_IDLE: begin
                if (w_accept && bus.we && !bus.is_bit && !w_illegal) begin
                    w_wr_idx = w_idx;
                    w_wd     = f_enc(bus.wdata);
                    w_sfr_wd = f_enc(bus.wdata);
                    w_lo_we  = (w_region == c_RG_LOW);
                    w_sfr_we = (w_region == c_RG_SFR);
                    w_up_we  = (w_region == c_RG_UP);
                end
            end
            c_ST_RMW: begin
                if (!w_rmw_abort) begin
                    w_wr_idx = r_rmw_idx;
                    w_wd     = f_enc(w_merged);
                    w_sfr_wd = f_enc(w_merged);
                    w_lo_we  = (r_rmw_region == c_RG_LOW);
                    w_sfr_we = (r_rmw_region == c_RG_SFR);
                    w_up_we  = (r_rmw_region == c_RG_UP);
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Sweep counter, response registers and RMW capture
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt        <= 7'd0;
            r_rvalid     <= 1'b0;
            r_rdata      <= 8'h00;
            r_rbit       <= 1'b0;
            r_err        <= 1'b0;
            r_rmw_region <= c_RG_LOW;
            r_rmw_idx    <= 7'd0;
            r_rmw_bsel   <= 3'd0;
            r_rmw_wbit   <= 1'b0;
            r_rmw_byte   <= 8'h00;
`ifdef IRAM_PARITY_EN
            r_rmw_bad    <= 1'b0;
`endif
        end else begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            if (r_state == c_ST_INIT) begin
                r_cnt <= r_cnt + 7'd1;
            end
            if (w_accept) begin
                if (!bus.we) begin
                    r_rvalid <= 1'b1;
                    if (w_illegal) begin
                        r_rdata <= 8'h00;
                        r_rbit  <= 1'b0;
                        r_err   <= 1'b1;
                    end else begin
                        r_rdata <= w_rd_byte;
                        r_rbit  <= bus.is_bit ? w_rd_byte[w_bsel] : 1'b0;
                        r_err   <= w_rd_bad;
                    end
                end else if (w_illegal) begin
                    r_err <= 1'b1;
                end else if (bus.is_bit) begin
                    // The target byte is read now so the merge needs no extra read cycle.
                    r_rmw_region <= w_region;
                    r_rmw_idx    <= w_idx;
                    r_rmw_bsel   <= w_bsel;
                    r_rmw_wbit   <= bus.wbit;
                    r_rmw_byte   <= w_rd_byte;
`ifdef IRAM_PARITY_EN
                    r_rmw_bad    <= w_rd_bad;
`endif
                end
            end
            if (w_rmw_abort) begin
                r_err <= 1'b1;
            end
        end
    end

    a_quiet_init: assert property (@(posedge clock) disable iff (reset)
        (r_state == c_ST_INIT) |-> !(r_rvalid || r_err));

    a_rmw_single: assert property (@(posedge clock) disable iff (reset)
        (r_state == c_ST_RMW) |=> (r_state == c_ST_IDLE));

endmodule
`default_nettype wire

// File: tb/tb_iram_bitrmw_ctrl.sv
`default_nettype none
// Bench for iram_bitrmw_ctrl: one instance with upper RAM, one without.
module tb_iram_bitrmw_ctrl;

    localparam logic [7:0] c_FILL = 8'h00;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       req_a = 1'b0;
    logic       req_b = 1'b0;
    logic       t_we = 1'b0, t_bit = 1'b0, t_ind = 1'b0, t_wbit = 1'b0;
    logic [7:0] t_addr = 8'h00, t_wdata = 8'h00;

    iram_bitrmw_ctrl_if bif_a ();
    iram_bitrmw_ctrl_if bif_b ();

    assign bif_a.req = req_a;   assign bif_b.req = req_b;
    assign bif_a.we = t_we;     assign bif_b.we = t_we;
    assign bif_a.is_bit = t_bit; assign bif_b.is_bit = t_bit;
    assign bif_a.indirect = t_ind; assign bif_b.indirect = t_ind;
    assign bif_a.addr = t_addr; assign bif_b.addr = t_addr;
    assign bif_a.wdata = t_wdata; assign bif_b.wdata = t_wdata;
    assign bif_a.wbit = t_wbit; assign bif_b.wbit = t_wbit;

    iram_bitrmw_ctrl #(.LOW_DEPTH(128), .UPPER_EN(1), .FILL_VALUE(c_FILL), .SFR_FILL(8'h00))
        dut_a (.clock(clk), .reset(rst), .bus(bif_a.slave));
    iram_bitrmw_ctrl #(.LOW_DEPTH(128), .UPPER_EN(0), .FILL_VALUE(c_FILL), .SFR_FILL(8'h00))
        dut_b (.clock(clk), .reset(rst), .bus(bif_b.slave));

    typedef struct {
        string      name;
        bit         sel;
        bit         we;
        bit         is_bit;
        bit         ind;
        logic [7:0] addr;
        logic [7:0] wdata;
        bit         wbit;
        bit         exp_rv;
        logic [7:0] exp_d;
        bit         exp_b;
        bit         exp_e;
    } vec_t;

    typedef struct {
        string      name;
        bit         rv;
        logic [7:0] d;
        bit         b;
        bit         e;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t f_mk(input string nm, input bit sel, input bit we, input bit isb,
                                  input bit ind, input logic [7:0] a, input logic [7:0] wd,
                                  input bit wb, input bit rv, input logic [7:0] d,
                                  input bit b, input bit e);
        vec_t v;
        v.name = nm; v.sel = sel; v.we = we; v.is_bit = isb; v.ind = ind;
        v.addr = a; v.wdata = wd; v.wbit = wb;
        v.exp_rv = rv; v.exp_d = d; v.exp_b = b; v.exp_e = e;
        return v;
    endfunction

    // Drive one request, wait (bounded) for acceptance, queue the expected response.
    task automatic do_req(input vec_t v, output int waited);
        int   n;
        bit   rdy;
        exp_t x;
        n = 0;
        rdy = 1'b0;
        t_we = v.we; t_bit = v.is_bit; t_ind = v.ind;
        t_addr = v.addr; t_wdata = v.wdata; t_wbit = v.wbit;
        if (v.sel) req_b = 1'b1; else req_a = 1'b1;
        forever begin
            rdy = v.sel ? bif_b.ready : bif_a.ready;
            @(posedge clk);
            if (rdy) break;
            n++;
            if (n > 300) begin
                chk({v.name, ".accept_timeout"}, n, 0);
                break;
            end
            #1;
        end
        waited = n;
        if (rdy && (v.exp_rv || v.exp_e)) begin
            x.name = v.name; x.rv = v.exp_rv; x.d = v.exp_d; x.b = v.exp_b; x.e = v.exp_e;
            if (v.sel) q_b.push_back(x); else q_a.push_back(x);
        end
        #1;
        req_a = 1'b0;
        req_b = 1'b0;
    endtask

    task automatic resp(input bit sel, input logic rv, input logic [7:0] d,
                        input logic b, input logic e);
        exp_t x;
        if ((sel ? q_b.size() : q_a.size()) == 0) begin
            chk(sel ? "unexpected_pulse_b" : "unexpected_pulse_a", {30'd0, rv, e}, 0);
        end else begin
            x = sel ? q_b.pop_front() : q_a.pop_front();
            chk({x.name, ".rvalid"}, rv, x.rv);
            chk({x.name, ".err"}, e, x.e);
            if (x.rv) begin
                chk({x.name, ".rdata"}, d, x.d);
                chk({x.name, ".rbit"}, b, x.b);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bif_a.rvalid || bif_a.err) resp(1'b0, bif_a.rvalid, bif_a.rdata, bif_a.rbit, bif_a.err);
            if (bif_b.rvalid || bif_b.err) resp(1'b1, bif_b.rvalid, bif_b.rdata, bif_b.rbit, bif_b.err);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        int   n;

        // Columns: name, sel(0=A,1=B), we, is_bit, ind, addr, wdata, wbit, exp_rv, exp_d, exp_b, exp_e
        tbl.push_back(f_mk("w30",      0, 1, 0, 0, 8'h30, 8'hA5, 0, 0, 8'h00, 0, 0));
        tbl.push_back(f_mk("r30_fwd",  0, 0, 0, 0, 8'h30, 8'h00, 0, 1, 8'hA5, 0, 0));
        tbl.push_back(f_mk("r21",      0, 0, 0, 0, 8'h21, 8'h00, 0, 1, 8'h08, 0, 0));
        tbl.push_back(f_mk("rb0B",     0, 0, 1, 0, 8'h0B, 8'h00, 0, 1, 8'h08, 1, 0));
        tbl.push_back(f_mk("rb0A",     0, 0, 1, 0, 8'h0A, 8'h00, 0, 1, 8'h08, 0, 0));
        tbl.push_back(f_mk("wbE7",     0, 1, 1, 0, 8'hE7, 8'h00, 1, 0, 8'h00, 0, 0));
        tbl.push_back(f_mk("rE0_dir",  0, 0, 0, 0, 8'hE0, 8'h00, 0, 1, 8'h80, 0, 0));
        tbl.push_back(f_mk("rE0_ind",  0, 0, 0, 1, 8'hE0, 8'h00, 0, 1, 8'h00, 0, 0));
        tbl.push_back(f_mk("wE0_ind",  0, 1, 0, 1, 8'hE0, 8'h5A, 0, 0, 8'h00, 0, 0));
        tbl.push_back(f_mk("rE0_ind2", 0, 0, 0, 1, 8'hE0, 8'h00, 0, 1, 8'h5A, 0, 0));
        tbl.push_back(f_mk("rE0_dir2", 0, 0, 0, 0, 8'hE0, 8'h00, 0, 1, 8'h80, 0, 0));
        tbl.push_back(f_mk("rbE7",     0, 0, 1, 0, 8'hE7, 8'h00, 0, 1, 8'h80, 1, 0));
        tbl.push_back(f_mk("wb0B_0",   0, 1, 1, 0, 8'h0B, 8'h00, 0, 0, 8'h00, 0, 0));
        tbl.push_back(f_mk("wb0C_1",   0, 1, 1, 0, 8'h0C, 8'h00, 1, 0, 8'h00, 0, 0));
        tbl.push_back(f_mk("r21_b2b",  0, 0, 0, 0, 8'h21, 8'h00, 0, 1, 8'h10, 0, 0));
        tbl.push_back(f_mk("wb7F",     0, 1, 1, 0, 8'h7F, 8'h00, 1, 0, 8'h00, 0, 0));
        tbl.push_back(f_mk("r2F",      0, 0, 0, 0, 8'h2F, 8'h00, 0, 1, 8'h80, 0, 0));
        tbl.push_back(f_mk("w7F",      0, 1, 0, 0, 8'h7F, 8'h3C, 0, 0, 8'h00, 0, 0));
        tbl.push_back(f_mk("r7F",      0, 0, 0, 0, 8'h7F, 8'h00, 0, 1, 8'h3C, 0, 0));
        tbl.push_back(f_mk("w00",      0, 1, 0, 0, 8'h00, 8'h11, 0, 0, 8'h00, 0, 0));
        tbl.push_back(f_mk("r00",      0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 8'h11, 0, 0));
        tbl.push_back(f_mk("r30_ind",  0, 0, 0, 1, 8'h30, 8'h00, 0, 1, 8'hA5, 0, 0));
        tbl.push_back(f_mk("b_r90_ind",1, 0, 0, 1, 8'h90, 8'h00, 0, 1, 8'h00, 0, 1));
        tbl.push_back(f_mk("b_w90_ind",1, 1, 0, 1, 8'h90, 8'hFF, 0, 0, 8'h00, 0, 1));
        tbl.push_back(f_mk("b_r90_dir",1, 0, 0, 0, 8'h90, 8'h00, 0, 1, 8'h00, 0, 0));
        tbl.push_back(f_mk("b_rb0B",   1, 0, 1, 0, 8'h0B, 8'h00, 0, 1, 8'h00, 0, 0));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", bif_a.ready, 0);
        chk("rst_rvalid", bif_a.rvalid, 0);
        chk("rst_rdata", bif_a.rdata, 0);
        chk("rst_rbit", bif_a.rbit, 0);
        chk("rst_err", bif_a.err, 0);
        chk("rst_init_done", bif_a.init_done, 0);
        rst = 1'b0;
        #2;
        chk("init_done_low", bif_a.init_done, 0);
        #(-2 + 2);

        // Init sweep: request held from the first cycle is ignored for 128 cycles
        do_req(f_mk("init_r30", 0, 0, 0, 0, 8'h30, 8'h00, 0, 1, c_FILL, 0, 0), n);
        chk("init_wait_cycles", n, 128);
        chk("init_done_high", bif_a.init_done, 1);
        chk("init_done_high_b", bif_b.init_done, 1);

        // Bit write: ready drops for exactly one cycle
        do_req(f_mk("wb0B_1", 0, 1, 1, 0, 8'h0B, 8'h00, 1, 0, 8'h00, 0, 0), n);
        chk("bw_ready_low", bif_a.ready, 0);
        @(posedge clk); #1;
        chk("bw_ready_back", bif_a.ready, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            do_req(tbl[i], n);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("drain_a", q_a.size(), 0);
        chk("drain_b", q_b.size(), 0);

        // Reset in the middle of an RMW: the write is lost and the sweep restarts
        do_req(f_mk("rst_wb0B", 0, 1, 1, 0, 8'h0B, 8'h00, 1, 0, 8'h00, 0, 0), n);
        rst = 1'b1;
        #1;
        chk("rmw_rst_ready", bif_a.ready, 0);
        chk("rmw_rst_init_done", bif_a.init_done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        do_req(f_mk("reinit_r21", 0, 0, 0, 0, 8'h21, 8'h00, 0, 1, c_FILL, 0, 0), n);
        chk("reinit_wait_cycles", n, 128);

`ifdef IRAM_PARITY_EN
        do_req(f_mk("par_w40", 0, 1, 0, 0, 8'h40, 8'h77, 0, 0, 8'h00, 0, 0), n);
        @(posedge clk); #1;
        dut_a.r_lower[64][8] = ~dut_a.r_lower[64][8];
        do_req(f_mk("par_r40", 0, 0, 0, 0, 8'h40, 8'h00, 0, 1, 8'h77, 0, 1), n);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("final_drain_a", q_a.size(), 0);
        chk("final_drain_b", q_b.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
